control_unit_mc: RTL and testbench

Multi-cycle successor to the single-cycle RV32I control unit. It sequences each instruction through FETCH, DECODE, EXEC, MEM, WB and TRAP states, and handshakes with memory through mem_ready. It adds access-timeout traps, illegal-instruction and ECALL traps, an external stall, and an optional multi-cycle RV32M path. It drives the datapath enables and muxes that the single-cycle decoders drove combinationally.

---
 rtl/control_unit_mc_if.sv | 37 +++
 rtl/control_unit_mc.sv | 247 ++++++++++++++++++++++++
 tb/tb_control_unit_mc.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_mc_if.sv
// Bundles the instruction fields, memory/stall handshake and datapath controls
// that pass between the multi-cycle control unit and its surroundings.
interface control_unit_mc_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       flags;
  logic       mem_ready;
  logic       stall;

  logic       pc_we;
  logic       ir_we;
  logic       iord;
  logic       mem_r;
  logic       mem_w;
  logic       reg_w;
  logic       alu_s;
  logic [1:0] data_s;
  logic [4:0] alu_op;
  logic [1:0] pc_src;
  logic       trap;
  logic [3:0] trap_cause;
  logic       instr_done;
  logic [2:0] state;

  modport master (
    output opcode, funct3, funct7, flags, mem_ready, stall,
    input  pc_we, ir_we, iord, mem_r, mem_w, reg_w, alu_s, data_s, alu_op,
           pc_src, trap, trap_cause, instr_done, state
  );

  modport slave (
    input  opcode, funct3, funct7, flags, mem_ready, stall,
    output pc_we, ir_we, iord, mem_r, mem_w, reg_w, alu_s, data_s, alu_op,
           pc_src, trap, trap_cause, instr_done, state
  );
endinterface

// File: rtl/control_unit_mc.sv
// Multi-cycle RV32I(M) control unit: FETCH/DECODE/EXEC/MEM/WB/TRAP sequencer
// with memory-ready handshake, access timeouts, illegal/ECALL traps and stall.
module control_unit_mc #(
  parameter int MEM_TIMEOUT = 15,
  parameter bit MUL_EN      = 1'b1,
  parameter int MUL_CYCLES  = 4
) (
  input logic              clk,
  input logic              rst,
  control_unit_mc_if.slave bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [5:0] MUL_LAST  = 6'(MUL_CYCLES - 1);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] waitCnt_q, waitCnt_d;
  logic [5:0] mulCnt_q, mulCnt_d;
  logic [3:0] cause_q, cause_d;

  logic isOp, isOpImm, isLoad, isStore, isBranch, isJal, isJalr, isLui, isAuipc;
  logic isEcall, isMul, opLegal, illegal, altBit;
  logic [4:0] instrAluOp;
  logic       instrAluS;

  logic pcWe, irWe, iord, memR, memW, regW, aluS, trap, done;
  logic [1:0] dataS, pcSrc;
  logic [4:0] aluOp;
  logic       timedOut;

  assign isOp     = (bus.opcode == OPC_OP);
  assign isOpImm  = (bus.opcode == OPC_OPIMM);
  assign isLoad   = (bus.opcode == OPC_LOAD);
  assign isStore  = (bus.opcode == OPC_STORE);
  assign isBranch = (bus.opcode == OPC_BRANCH);
  assign isJal    = (bus.opcode == OPC_JAL);
  assign isJalr   = (bus.opcode == OPC_JALR);
  assign isLui    = (bus.opcode == OPC_LUI);
  assign isAuipc  = (bus.opcode == OPC_AUIPC);
  assign isEcall  = (bus.opcode == OPC_SYSTEM) && (bus.funct3 == 3'b000);
  assign isMul    = isOp && (bus.funct7 == 7'b0000001);

  assign opLegal = (bus.funct7 == 7'b0000000)
                 || ((bus.funct7 == 7'b0100000) && ((bus.funct3 == 3'b000) || (bus.funct3 == 3'b101)))
                 || (isMul && MUL_EN);
  assign illegal = !((isOp && opLegal) || isOpImm || isLoad || isStore || isBranch
                     || isJal || isJalr || isLui || isAuipc || isEcall);

  assign altBit = (isOp && bus.funct7[5])
                || (isOpImm && (bus.funct3 == 3'b101) && bus.funct7[5]);

  // ALU controls are held from EXEC through MEM/WB so the address and result stay stable.
  always_comb begin
    instrAluOp = 5'b00000;
    instrAluS  = 1'b0;
    if (isMul) begin
      instrAluOp = {2'b11, bus.funct3};
    end else if (isOp) begin
      instrAluOp = {1'b0, altBit, bus.funct3};
    end else if (isOpImm) begin
      instrAluOp = {1'b0, altBit, bus.funct3};
      instrAluS  = 1'b1;
    end else if (isLoad || isStore || isAuipc) begin
      instrAluS  = 1'b1;
    end else if (isBranch) begin
      instrAluOp = {2'b10, bus.funct3};
    end
  end

  assign timedOut = (waitCnt_q == WAIT_LAST);

  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    mulCnt_d  = mulCnt_q;
    cause_d   = cause_q;
    pcWe  = 1'b0;
    irWe  = 1'b0;
    iord  = 1'b0;
    memR  = 1'b0;
    memW  = 1'b0;
    regW  = 1'b0;
    aluS  = 1'b0;
    dataS = 2'b00;
    aluOp = 5'b00000;
    pcSrc = 2'b00;
    trap  = 1'b0;
    done  = 1'b0;

    case (state_q)
      FETCH: begin
        memR = 1'b1;
        if (bus.mem_ready) begin
          irWe    = 1'b1;
          state_d = DECODE;
        end else if (timedOut) begin
          state_d = TRAP;
          cause_d = 4'd1;
        end else begin
          waitCnt_d = waitCnt_q + 8'd1;
        end
      end
      DECODE: begin
        if (illegal) begin
          state_d = TRAP;
          cause_d = 4'd2;
        end else if (isEcall) begin
          state_d = TRAP;
          cause_d = 4'd11;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        aluOp = instrAluOp;
        aluS  = instrAluS;
        if (isMul) begin
          if (mulCnt_q == MUL_LAST) state_d = WB;
          else                      mulCnt_d = mulCnt_q + 6'd1;
        end else if (isLoad || isStore) begin
          state_d = MEM;
        end else if (isBranch) begin
          pcWe    = 1'b1;
          pcSrc   = {1'b0, bus.flags};
          done    = 1'b1;
          state_d = FETCH;
        end else if (isJal || isJalr) begin
          regW    = 1'b1;
          dataS   = 2'b10;
          pcWe    = 1'b1;
          pcSrc   = isJal ? 2'b01 : 2'b10;
          done    = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        iord  = 1'b1;
        aluOp = instrAluOp;
        aluS  = instrAluS;
        memR  = isLoad;
        memW  = isStore;
        if (bus.mem_ready) begin
          if (isStore) begin
            pcWe    = 1'b1;
            done    = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (timedOut) begin
          state_d = TRAP;
          cause_d = isStore ? 4'd7 : 4'd5;
        end else begin
          waitCnt_d = waitCnt_q + 8'd1;
        end
      end
      WB: begin
        aluOp   = instrAluOp;
        aluS    = instrAluS;
        regW    = 1'b1;
        dataS   = isLoad ? 2'b01 : (isLui ? 2'b11 : 2'b00);
        pcWe    = 1'b1;
        done    = 1'b1;
        state_d = FETCH;
      end
      TRAP: begin
        trap    = 1'b1;
        pcWe    = 1'b1;
        pcSrc   = 2'b11;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    if (state_d != state_q) begin
      waitCnt_d = 8'd0;
      mulCnt_d  = 6'd0;
    end

    // A stall freezes all sequencing and suppresses every side effect, but keeps the read address up.
    if (bus.stall) begin
      state_d   = state_q;
      waitCnt_d = waitCnt_q;
      mulCnt_d  = mulCnt_q;
      cause_d   = cause_q;
      pcWe = 1'b0;
      irWe = 1'b0;
      regW = 1'b0;
      memW = 1'b0;
      trap = 1'b0;
      done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FETCH;
      waitCnt_q <= 8'd0;
      mulCnt_q  <= 6'd0;
      cause_q   <= 4'd0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      mulCnt_q  <= mulCnt_d;
      cause_q   <= cause_d;
    end
  end

  // Gating with rst kills every enable the instant reset asserts, independent of the clock.
  assign bus.pc_we      = rst & pcWe;
  assign bus.ir_we      = rst & irWe;
  assign bus.iord       = rst & iord;
  assign bus.mem_r      = rst & memR;
  assign bus.mem_w      = rst & memW;
  assign bus.reg_w      = rst & regW;
  assign bus.alu_s      = rst & aluS;
  assign bus.data_s     = rst ? dataS : 2'b00;
  assign bus.alu_op     = rst ? aluOp : 5'b00000;
  assign bus.pc_src     = rst ? pcSrc : 2'b00;
  assign bus.trap       = rst & trap;
  assign bus.trap_cause = rst ? cause_q : 4'd0;
  assign bus.instr_done = rst & done;
  assign bus.state      = rst ? state_q : FETCH;

endmodule

// File: tb/tb_control_unit_mc.sv
// Bench for control_unit_mc: decode-legality table, randomized instruction
// traces from a per-instruction timing model, and hand-built corner sequences.
module tb_control_unit_mc;
  localparam int TIMEOUT = 15;
  localparam int MULC    = 4;

  logic clk;
  logic rst;

  control_unit_mc_if bus();
  control_unit_mc_if bus2();

  control_unit_mc #(.MEM_TIMEOUT(TIMEOUT), .MUL_EN(1'b1), .MUL_CYCLES(MULC)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  control_unit_mc #(.MEM_TIMEOUT(TIMEOUT), .MUL_EN(1'b0), .MUL_CYCLES(MULC)) dutNoMul (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  assign bus2.opcode    = bus.opcode;
  assign bus2.funct3    = bus.funct3;
  assign bus2.funct7    = bus.funct7;
  assign bus2.flags     = bus.flags;
  assign bus2.mem_ready = bus.mem_ready;
  assign bus2.stall     = bus.stall;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [2:0] st;
    logic       pcWe, irWe, iord, memR, memW, regW, aluS;
    logic [1:0] dataS;
    logic [4:0] aluOp;
    logic [1:0] pcSrc;
    logic       trap;
    logic [3:0] cause;
    logic       done;
  } outs_t;

  typedef struct {
    logic  memReady;
    logic  flags;
    outs_t exp;
  } frame_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [2:0] nextSt;
    logic [3:0] cause;
  } decVec_t;

  frame_t     trace[$];
  int         checks = 0;
  int         errors = 0;
  int         frameNo = 0;
  logic [3:0] modelCause = 4'd0;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic outs_t readDut();
    outs_t o;
    o.st = bus.state;     o.pcWe = bus.pc_we;   o.irWe = bus.ir_we;   o.iord = bus.iord;
    o.memR = bus.mem_r;   o.memW = bus.mem_w;   o.regW = bus.reg_w;   o.aluS = bus.alu_s;
    o.dataS = bus.data_s; o.aluOp = bus.alu_op; o.pcSrc = bus.pc_src; o.trap = bus.trap;
    o.cause = bus.trap_cause; o.done = bus.instr_done;
    return o;
  endfunction

  task automatic applyStimulus(input logic memReady, input logic flags, input logic stall);
    bus.mem_ready = memReady;
    bus.flags     = flags;
    bus.stall     = stall;
  endtask

  task automatic checkOutput(input outs_t want, input string name);
    outs_t got;
    got = readDut();
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic checkVal(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic setInstr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    bus.opcode = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
  endtask

  // Called on a falling edge; returns on a falling edge with reset released.
  task automatic doReset();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    #1;
    checkOutput('0, "resetZero");
    @(negedge clk);
    rst = 1'b1;
    modelCause = 4'd0;
    trace.delete();
  endtask

  task automatic doFrame(input frame_t f, input bit stallIt);
    outs_t want;
    applyStimulus(f.memReady, f.flags, stallIt);
    #1;
    want = f.exp;
    if (stallIt) begin
      want.pcWe = 1'b0; want.irWe = 1'b0; want.regW = 1'b0;
      want.memW = 1'b0; want.trap = 1'b0; want.done = 1'b0;
    end
    checkOutput(want, $sformatf("%s%0d_st%0d", stallIt ? "stall" : "frame", frameNo, want.st));
    frameNo++;
    @(negedge clk);
  endtask

  task automatic runFrames(input int n, input bit randStall);
    for (int i = 0; i < n && trace.size() > 0; i++) begin
      if (randStall && $urandom_range(0, 9) == 0) begin
        int k;
        k = $urandom_range(1, 3);
        for (int s = 0; s < k; s++) doFrame(trace[0], 1'b1);
      end
      doFrame(trace.pop_front(), 1'b0);
    end
  endtask

  function automatic outs_t blank(input logic [2:0] st);
    outs_t o;
    o = '0;
    o.st = st;
    o.cause = modelCause;
    return o;
  endfunction

  task automatic pushFrame(input logic mr, input logic fl, input outs_t o);
    frame_t f;
    f.memReady = mr;
    f.flags    = fl;
    f.exp      = o;
    trace.push_back(f);
  endtask

  task automatic pushTrap(input logic [3:0] c);
    outs_t o;
    modelCause = c;
    o = blank(3'd5);
    o.trap = 1'b1; o.pcWe = 1'b1; o.pcSrc = 2'b11;
    pushFrame(rb(), rb(), o);
  endtask

  // Instruction-level timing model: one expected frame per clock for a whole instruction.
  task automatic buildTrace(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input int fd, input int md, input logic brFlag);
    outs_t o;
    bit isOp, isImm, isLd, isSt, isBr, isJal, isJalr, isLui, isAuipc, ecall, isMul, legal;
    logic [4:0] aOp;
    logic       aS;
    isOp = (op == 7'b0110011);   isImm = (op == 7'b0010011);  isLd = (op == 7'b0000011);
    isSt = (op == 7'b0100011);   isBr = (op == 7'b1100011);   isJal = (op == 7'b1101111);
    isJalr = (op == 7'b1100111); isLui = (op == 7'b0110111);  isAuipc = (op == 7'b0010111);
    ecall = (op == 7'b1110011) && (f3 == 3'd0);
    isMul = isOp && (f7 == 7'h01);
    if (isOp) legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) || isMul;
    else      legal = isImm || isLd || isSt || isBr || isJal || isJalr || isLui || isAuipc || ecall;

    aOp = 5'd0;
    aS  = 1'b0;
    if (isMul)                     aOp = {2'b11, f3};
    else if (isOp)                 aOp = {1'b0, f7[5], f3};
    else if (isImm) begin          aOp = {1'b0, (f3 == 3'd5) && f7[5], f3}; aS = 1'b1; end
    else if (isLd || isSt || isAuipc) aS = 1'b1;
    else if (isBr)                 aOp = {2'b10, f3};

    for (int i = 0; i < fd && i < TIMEOUT; i++) begin
      o = blank(3'd0); o.memR = 1'b1;
      pushFrame(1'b0, rb(), o);
    end
    if (fd >= TIMEOUT) begin pushTrap(4'd1); return; end
    o = blank(3'd0); o.memR = 1'b1; o.irWe = 1'b1;
    pushFrame(1'b1, rb(), o);
    pushFrame(rb(), rb(), blank(3'd1));
    if (!legal) begin pushTrap(4'd2); return; end
    if (ecall)  begin pushTrap(4'd11); return; end

    o = blank(3'd2); o.aluOp = aOp; o.aluS = aS;
    if (isBr) begin
      o.pcWe = 1'b1; o.pcSrc = {1'b0, brFlag}; o.done = 1'b1;
      pushFrame(rb(), brFlag, o);
      return;
    end
    if (isJal || isJalr) begin
      o.regW = 1'b1; o.dataS = 2'b10; o.pcWe = 1'b1; o.done = 1'b1;
      o.pcSrc = isJal ? 2'b01 : 2'b10;
      pushFrame(rb(), rb(), o);
      return;
    end
    for (int i = 0; i < (isMul ? MULC : 1); i++) pushFrame(rb(), rb(), o);

    if (isLd || isSt) begin
      for (int i = 0; i < md && i < TIMEOUT; i++) begin
        o = blank(3'd3); o.iord = 1'b1; o.aluS = 1'b1; o.memR = isLd; o.memW = isSt;
        pushFrame(1'b0, rb(), o);
      end
      if (md >= TIMEOUT) begin pushTrap(isSt ? 4'd7 : 4'd5); return; end
      o = blank(3'd3); o.iord = 1'b1; o.aluS = 1'b1; o.memR = isLd; o.memW = isSt;
      if (isSt) begin
        o.pcWe = 1'b1; o.done = 1'b1;
        pushFrame(1'b1, rb(), o);
        return;
      end
      pushFrame(1'b1, rb(), o);
    end

    o = blank(3'd4); o.aluOp = aOp; o.aluS = aS;
    o.regW = 1'b1; o.pcWe = 1'b1; o.done = 1'b1;
    o.dataS = isLd ? 2'b01 : (isLui ? 2'b11 : 2'b00);
    pushFrame(rb(), rb(), o);
  endtask

  task automatic runInstr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input int fd, input int md, input logic brFlag, input bit randStall);
    setInstr(op, f3, f7);
    buildTrace(op, f3, f7, fd, md, brFlag);
    runFrames(1000, randStall);
  endtask

  decVec_t    decTable[$];
  logic [6:0] opList[12];

  initial begin
    decTable.push_back('{7'b0110011, 3'd0, 7'h00, 3'd2, 4'd0});
    decTable.push_back('{7'b0110011, 3'd0, 7'h20, 3'd2, 4'd0});
    decTable.push_back('{7'b0110011, 3'd5, 7'h20, 3'd2, 4'd0});
    decTable.push_back('{7'b0110011, 3'd1, 7'h20, 3'd5, 4'd2});
    decTable.push_back('{7'b0110011, 3'd4, 7'h01, 3'd2, 4'd0});
    decTable.push_back('{7'b0110011, 3'd0, 7'h02, 3'd5, 4'd2});
    decTable.push_back('{7'b0010011, 3'd5, 7'h20, 3'd2, 4'd0});
    decTable.push_back('{7'b0000011, 3'd2, 7'h00, 3'd2, 4'd0});
    decTable.push_back('{7'b1101111, 3'd0, 7'h3f, 3'd2, 4'd0});
    decTable.push_back('{7'b0010111, 3'd0, 7'h00, 3'd2, 4'd0});
    decTable.push_back('{7'b1110011, 3'd0, 7'h00, 3'd5, 4'd11});
    decTable.push_back('{7'b1110011, 3'd1, 7'h00, 3'd5, 4'd2});
    decTable.push_back('{7'b0001111, 3'd0, 7'h00, 3'd5, 4'd2});
    decTable.push_back('{7'b0000000, 3'd0, 7'h00, 3'd5, 4'd2});

    opList = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
               7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011, 7'b0110011, 7'b0000011};

    rst = 1'b1;
    setInstr(7'd0, 3'd0, 7'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(negedge clk);

    // Decode table: one ready fetch, one decode, then inspect where the unit went.
    for (int i = 0; i < decTable.size(); i++) begin
      doReset();
      setInstr(decTable[i].op, decTable[i].f3, decTable[i].f7);
      applyStimulus(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      checkVal($sformatf("dec%0d_state", i), 8'(bus.state), 8'(decTable[i].nextSt));
      checkVal($sformatf("dec%0d_cause", i), 8'(bus.trap_cause), 8'(decTable[i].cause));
      @(negedge clk);
    end

    doReset();
    runInstr(7'b0110011, 3'd0, 7'h00, 0, 0, 1'b0, 1'b0);
    runInstr(7'b0000011, 3'd2, 7'h00, 3, 3, 1'b0, 1'b0);
    runInstr(7'b0100011, 3'd2, 7'h00, 0, 99, 1'b0, 1'b0);
    runInstr(7'b1100011, 3'd0, 7'h00, 0, 0, 1'b1, 1'b0);
    runInstr(7'b1100011, 3'd0, 7'h00, 0, 0, 1'b0, 1'b0);
    runInstr(7'b1110011, 3'd0, 7'h00, 1, 0, 1'b0, 1'b0);
    runInstr(7'b0110111, 3'd3, 7'h11, 0, 0, 1'b0, 1'b0);
    runInstr(7'b0110011, 3'd0, 7'h00, 20, 0, 1'b0, 1'b0);
    runInstr(7'b0000011, 3'd2, 7'h00, 0, 14, 1'b0, 1'b0);

    // Five stall cycles inside a 14-cycle fetch wait must not push it over the timeout.
    setInstr(7'b0110011, 3'd0, 7'h20);
    buildTrace(7'b0110011, 3'd0, 7'h20, 14, 0, 1'b0);
    runFrames(3, 1'b0);
    for (int s = 0; s < 5; s++) doFrame(trace[0], 1'b1);
    runFrames(1000, 1'b0);

    // MUL: the MUL_EN=1 unit holds EXEC, the MUL_EN=0 unit traps as illegal.
    doReset();
    setInstr(7'b0110011, 3'd0, 7'h01);
    buildTrace(7'b0110011, 3'd0, 7'h01, 0, 0, 1'b0);
    runFrames(2, 1'b0);
    #1;
    checkVal("noMul_state", 8'(bus2.state), 8'd5);
    checkVal("noMul_cause", 8'(bus2.trap_cause), 8'd2);
    runFrames(1000, 1'b0);

    // Async reset in the middle of a load's memory wait.
    setInstr(7'b0000011, 3'd2, 7'h00);
    buildTrace(7'b0000011, 3'd2, 7'h00, 0, 99, 1'b0);
    runFrames(6, 1'b0);
    trace.delete();
    applyStimulus(1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput('0, "rstAsync");
    @(posedge clk);
    #1;
    checkOutput('0, "rstHold");
    @(negedge clk);
    rst = 1'b1;
    modelCause = 4'd0;

    for (int n = 0; n < 120; n++) begin
      logic [6:0] op, f7;
      logic [2:0] f3;
      int fd, md;
      op = ($urandom_range(0, 15) == 0) ? 7'($urandom) : opList[$urandom_range(0, 11)];
      f3 = 3'($urandom);
      if (op == 7'b1110011 && rb()) f3 = 3'd0;
      case ($urandom_range(0, 3))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        2:       f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      fd = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 3);
      md = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 3);
      runInstr(op, f3, f7, fd, md, rb(), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
